des_cbc_ctrl: RTL

Sequencer for the single-block DES core (des). It accepts a stream of 64-bit blocks over a valid/ready handshake and drives the core's din, key and mode. It issues one start pulse per block and waits for the core's oflag, then returns results over a valid/ready output. It applies CBC chaining around the core, so multi-block messages run through one core instance.

---
 rtl/des_ctrl_pkg.sv | 17 +
 rtl/des_chain_unit.sv | 53 +++++
 rtl/des_cbc_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/des_ctrl_pkg.sv
// Shared types and constants for the DES block sequencer.
// Build option: DES_CBC_EN enables CBC chaining.
package des_ctrl_pkg;

  localparam int DES_BLK_W = 64;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    OUT
  } state_e;

endpackage

// File: rtl/des_chain_unit.sv
// CBC chain register with pre-core and post-core XOR muxing.
// Only instantiated when DES_CBC_EN is defined.
module des_chain_unit
  import des_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_i,
  input  logic                 cbc_i,
  input  logic                 mode_i,
  input  logic                 acc_i,
  input  logic                 done_i,
  input  logic [0:DES_BLK_W-1] iv_i,
  input  logic [0:DES_BLK_W-1] blk_i,
  input  logic [0:DES_BLK_W-1] dout_i,
  output logic [0:DES_BLK_W-1] din_o,
  output logic [0:DES_BLK_W-1] res_o
);

  logic                 cbc_q;
  logic [0:DES_BLK_W-1] chain_q;
  logic [0:DES_BLK_W-1] blk_q;

  logic enc_cbc;
  logic dec_cbc;

  assign enc_cbc = cbc_q && (mode_i == MODE_ENC);
  assign dec_cbc = cbc_q && (mode_i == MODE_DEC);

  assign din_o = enc_cbc ? (blk_i ^ chain_q) : blk_i;
  assign res_o = dec_cbc ? (dout_i ^ chain_q) : dout_i;

  // Decrypt chains on the ciphertext that went in, not the core output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cbc_q   <= 1'b0;
      chain_q <= '0;
      blk_q   <= '0;
    end else begin
      if (load_i) begin
        cbc_q   <= cbc_i;
        chain_q <= iv_i;
      end
      if (acc_i) begin
        blk_q <= blk_i;
      end
      if (done_i && cbc_q) begin
        chain_q <= (mode_i == MODE_ENC) ? dout_i : blk_q;
      end
    end
  end

endmodule

// File: rtl/des_cbc_ctrl.sv
// Block sequencer around a single-block DES core, ECB or CBC.
// Build option: DES_CBC_EN enables the chain unit.
module des_cbc_ctrl
  import des_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cfg_load,
  input  logic                 cfg_mode,
  input  logic                 cfg_cbc,
  input  logic [0:DES_BLK_W-1] cfg_key,
  input  logic [0:DES_BLK_W-1] cfg_iv,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [0:DES_BLK_W-1] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [0:DES_BLK_W-1] out_data,
  output logic [0:DES_BLK_W-1] des_din,
  output logic [0:DES_BLK_W-1] des_key,
  output logic                 des_mode,
  output logic                 des_start,
  input  logic [0:DES_BLK_W-1] des_dout,
  input  logic                 des_oflag,
  output logic                 busy,
  output logic                 timeout_err,
  output logic [CNT_W-1:0]     blk_count
);

  localparam int TW = $clog2(TIMEOUT) + 1;

  state_e               state_q;
  logic [TW-1:0]        tmo_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 terr_q;
  logic                 ov_q;
  logic                 start_q;
  logic                 mode_q;
  logic [0:DES_BLK_W-1] key_q;
  logic [0:DES_BLK_W-1] din_q;
  logic [0:DES_BLK_W-1] od_q;

  logic                 idle;
  logic                 load;
  logic                 acc;
  logic                 done;
  logic [0:DES_BLK_W-1] din_pre;
  logic [0:DES_BLK_W-1] res;

  assign idle = (state_q == IDLE);
  assign load = idle && cfg_load;
  assign acc  = in_valid && in_ready;
  assign done = (state_q == WAIT) && des_oflag;

  assign in_ready    = reset && idle && !cfg_load;
  assign busy        = !idle;
  assign out_valid   = ov_q;
  assign out_data    = od_q;
  assign des_din     = din_q;
  assign des_key     = key_q;
  assign des_mode    = mode_q;
  assign des_start   = start_q;
  assign timeout_err = terr_q;
  assign blk_count   = cnt_q;

`ifdef DES_CBC_EN
  des_chain_unit u_chain (
    .clk    (clk),
    .rst_n  (reset),
    .load_i (load),
    .cbc_i  (cfg_cbc),
    .mode_i (mode_q),
    .acc_i  (acc),
    .done_i (done),
    .iv_i   (cfg_iv),
    .blk_i  (in_data),
    .dout_i (des_dout),
    .din_o  (din_pre),
    .res_o  (res)
  );
`else
  logic unused_cbc;
  assign unused_cbc = ^{cfg_cbc, cfg_iv};
  assign din_pre    = in_data;
  assign res        = des_dout;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      tmo_q   <= '0;
      cnt_q   <= '0;
      terr_q  <= 1'b0;
      ov_q    <= 1'b0;
      start_q <= 1'b0;
      mode_q  <= 1'b0;
      key_q   <= '0;
      din_q   <= '0;
      od_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cfg_load) begin
            key_q  <= cfg_key;
            mode_q <= cfg_mode;
            cnt_q  <= '0;
            terr_q <= 1'b0;
          end else if (in_valid) begin
            din_q   <= din_pre;
            start_q <= 1'b1;
            state_q <= START;
          end
        end
        START: begin
          start_q <= 1'b0;
          tmo_q   <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          // A result arriving on the expiry cycle still counts.
          if (des_oflag) begin
            od_q    <= res;
            ov_q    <= 1'b1;
            state_q <= OUT;
          end else if (tmo_q == TW'(TIMEOUT - 1)) begin
            terr_q  <= 1'b1;
            state_q <= IDLE;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        OUT: begin
          if (out_ready) begin
            ov_q    <= 1'b0;
            cnt_q   <= cnt_q + CNT_W'(1);
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
